// File: rtl/smc_pkg.sv
// smc_pkg: shared state encoding, widths and weighting/division constants for smc_rank_sum.
package smc_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SUM, S_DIV, S_OUT} state_t;
    localparam int SMC_DW = 10;
    localparam int SUM_W = 14;
    localparam logic [SUM_W-1:0] W_ID_A = 14'd3;
    localparam logic [SUM_W-1:0] W_ID_B = 14'd4;
    localparam logic [SUM_W-1:0] W_ID_C = 14'd5;
    localparam logic [SUM_W-1:0] W_GM = 14'd1;
    localparam logic [3:0] DIV_ID = 4'd12;
    localparam logic [3:0] DIV_GM = 4'd3;
    localparam logic [SUM_W-1:0] RND_ID = 14'd6;
    localparam logic [SUM_W-1:0] RND_GM = 14'd1;
endpackage

// File: rtl/smc_rank_sum_if.sv
// smc_rank_sum_if: input beat stream and result pulse of smc_rank_sum.
interface smc_rank_sum_if #(parameter int DW = 10);
    logic in_valid;
    logic in_ready;
    logic [DW-1:0] in_data;
    logic [1:0] in_mode;
    logic out_valid;
    logic [DW-1:0] out_data;
    modport master(output in_valid, in_data, in_mode, input in_ready, out_valid, out_data);
    modport slave(input in_valid, in_data, in_mode, output in_ready, out_valid, out_data);
endinterface

// File: rtl/smc_const_div.sv
// smc_const_div: restoring divider, one quotient bit per cycle for SUM_W cycles after start.
module smc_const_div
    import smc_pkg::*;
#(
    parameter int QW = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [3:0]       divisor,
    output logic             done,
    output logic [QW-1:0]    quotient
);
    logic [SUM_W-1:0] q, q_nx;
    logic [3:0] rem, rem_nx, dvs, cnt;
    logic [4:0] rem_sh;
    logic fits;
    assign rem_sh = {rem, q[SUM_W-1]};
    assign fits = rem_sh >= {1'b0, dvs};
    assign rem_nx = fits ? 4'(rem_sh - {1'b0, dvs}) : rem_sh[3:0];
    assign q_nx = {q[SUM_W-2:0], fits};
    // done flags the final step so the caller can capture the finished quotient on that edge
    assign done = cnt == 4'd1;
    assign quotient = q_nx[QW-1:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
            rem <= '0;
            dvs <= '0;
            cnt <= '0;
        end else if (start) begin
            q <= dividend;
            rem <= '0;
            dvs <= divisor;
            cnt <= 4'(SUM_W);
        end else if (cnt != 4'd0) begin
            q <= q_nx;
            rem <= rem_nx;
            cnt <= cnt - 4'd1;
        end
    end
endmodule

// File: rtl/smc_rank_sum.sv
// smc_rank_sum: sorts a frame of results, weights the top/bottom three and divides by a constant.
// Define SMC_ROUND_EN to round half-up instead of truncating the quotient.
module smc_rank_sum
    import smc_pkg::*;
#(
    parameter int N_IN = 6,
    parameter int DW = SMC_DW
) (
    input logic clk,
    input logic rst_n,
    smc_rank_sum_if.slave bus
);
    localparam int CW = $clog2(N_IN + 1);
    state_t state, state_nx;
    logic [CW-1:0] count;
    logic [1:0] mode;
    logic [DW-1:0] arr [N_IN];
    logic [DW-1:0] arr_nx [N_IN];
    logic [N_IN-1:0] ge;
    logic take, last, done;
    logic [DW-1:0] a, b, c, quot;
    logic [SUM_W-1:0] sum, rnd;
    assign bus.in_ready = (state == S_IDLE) || (state == S_LOAD);
    assign bus.out_valid = state == S_OUT;
    assign take = bus.in_valid && bus.in_ready;
    assign last = count == CW'(N_IN - 1);
    // ge is a contiguous prefix because arr is descending; the new beat lands just after it
    for (genvar i = 0; i < N_IN; i++) begin : g_ins
        assign ge[i] = (CW'(i) < count) && (arr[i] >= bus.in_data);
        if (i == 0) begin : g_first
            assign arr_nx[i] = ge[i] ? arr[i] : bus.in_data;
        end else begin : g_rest
            assign arr_nx[i] = ge[i] ? arr[i] : ge[i-1] ? bus.in_data : arr[i-1];
        end
    end
    assign a = mode[1] ? arr[0] : arr[N_IN-3];
    assign b = mode[1] ? arr[1] : arr[N_IN-2];
    assign c = mode[1] ? arr[2] : arr[N_IN-1];
`ifdef SMC_ROUND_EN
    assign rnd = mode[0] ? RND_ID : RND_GM;
`else
    assign rnd = '0;
`endif
    assign sum = (mode[0] ? W_ID_A : W_GM) * SUM_W'(a) + (mode[0] ? W_ID_B : W_GM) * SUM_W'(b)
               + (mode[0] ? W_ID_C : W_GM) * SUM_W'(c) + rnd;
    smc_const_div #(.QW(DW)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (state == S_SUM),
        .dividend (sum),
        .divisor  (mode[0] ? DIV_ID : DIV_GM),
        .done     (done),
        .quotient (quot)
    );
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: state_nx = take ? S_LOAD : S_IDLE;
            S_LOAD: state_nx = (take && last) ? S_SUM : S_LOAD;
            S_SUM: state_nx = S_DIV;
            S_DIV: state_nx = done ? S_OUT : S_DIV;
            default: state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            mode <= '0;
            bus.out_data <= '0;
            for (int k = 0; k < N_IN; k++) arr[k] <= '0;
        end else begin
            if (take) begin
                arr <= arr_nx;
                count <= last ? '0 : count + CW'(1);
            end
            if (take && state == S_IDLE) mode <= bus.in_mode;
            if (state == S_DIV && done) bus.out_data <= quot;
        end
    end
endmodule

// File: tb/tb_smc_rank_sum.sv
// tb_smc_rank_sum: table-driven frames plus reset/backpressure sequences, scoreboarded results.
module tb_smc_rank_sum;
    typedef logic [9:0] beats_t [6];
    typedef struct {
        beats_t b;
        logic [1:0] m;
        int e;
        int er;
    } vec_t;
    logic clk = 0;
    logic rst_n = 0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_exp = 0;
    int sb[$];
    int tq[$];
    vec_t tbl[7];
    smc_rank_sum_if #(.DW(10)) bus ();
    smc_rank_sum #(.N_IN(6), .DW(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got out_valid with data %0d, expected none", bus.out_data);
            end else begin
                int e, t;
                e = sb.pop_front();
                t = tq.pop_front();
                chk("out_data", int'(bus.out_data), e);
                chk("latency", cyc, t + 15);
            end
        end
    end
    function automatic int model(input beats_t b, input logic [1:0] m);
        int s[6];
        int t, x, y, z, sum;
        for (int i = 0; i < 6; i++) s[i] = int'(b[i]);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 5 - i; j++)
                if (s[j] < s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        x = m[1] ? s[0] : s[3];
        y = m[1] ? s[1] : s[4];
        z = m[1] ? s[2] : s[5];
        sum = m[0] ? 3 * x + 4 * y + 5 * z : x + y + z;
`ifdef SMC_ROUND_EN
        sum += m[0] ? 6 : 1;
`endif
        return (sum / (m[0] ? 12 : 3)) % 1024;
    endfunction
    task automatic put(input logic [9:0] d, input logic [1:0] m);
        int n = 0;
        bus.in_valid = 1;
        bus.in_data = d;
        bus.in_mode = m;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        end
        @(negedge clk);
        bus.in_valid = 0;
    endtask
    task automatic run_frame(input beats_t b, input logic [1:0] m, input int exp, input bit gaps, input bit push);
        for (int i = 0; i < 6; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            put(b[i], m);
        end
        if (push) begin
            sb.push_back(exp);
            tq.push_back(cyc);
            last_exp = exp;
        end
    endtask
    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
            sb.delete();
            tq.delete();
        end
    endtask
    task automatic reset_pulse();
        rst_n = 0;
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        @(negedge clk);
        rst_n = 1;
    endtask
    initial begin
        beats_t rb;
        logic [1:0] rm;
        tbl[0] = '{'{10'd10, 10'd50, 10'd30, 10'd20, 10'd60, 10'd40}, 2'b11, 48, 48};
        tbl[1] = '{'{10'd10, 10'd50, 10'd30, 10'd20, 10'd60, 10'd40}, 2'b00, 20, 20};
        tbl[2] = '{'{10'd0, 10'd0, 10'd0, 10'd2, 10'd2, 10'd1}, 2'b10, 1, 2};
        tbl[3] = '{'{10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023}, 2'b11, 1023, 1023};
        tbl[4] = '{'{10'd5, 10'd9, 10'd3, 10'd7, 10'd1, 10'd8}, 2'b01, 2, 3};
        tbl[5] = '{'{10'd5, 10'd9, 10'd3, 10'd7, 10'd1, 10'd8}, 2'b10, 8, 8};
        tbl[6] = '{'{10'd7, 10'd7, 10'd3, 10'd7, 10'd2, 10'd7}, 2'b01, 3, 4};
        bus.in_valid = 0;
        bus.in_data = 0;
        bus.in_mode = 0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", int'(bus.in_ready), 1);
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk("reset_out_data", int'(bus.out_data), 0);
        rst_n = 1;
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
`ifdef SMC_ROUND_EN
            run_frame(tbl[k].b, tbl[k].m, tbl[k].er, 0, 1);
`else
            run_frame(tbl[k].b, tbl[k].m, tbl[k].e, 0, 1);
`endif
            drain();
        end
        repeat (3) @(negedge clk);
        chk("out_data_hold", int'(bus.out_data), last_exp);
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 6; i++) rb[i] = 10'($urandom_range(0, 1023));
            rm = 2'($urandom_range(0, 3));
            run_frame(rb, rm, model(rb, rm), 1, 1);
            drain();
        end
        // in_valid held high through SUM/DIV must not be counted as beats
        run_frame(tbl[1].b, tbl[1].m, model(tbl[1].b, tbl[1].m), 1, 1);
        bus.in_valid = 1;
        bus.in_data = 10'd1023;
        bus.in_mode = 2'b11;
        repeat (15) @(negedge clk);
        bus.in_valid = 0;
        drain();
        run_frame(tbl[0].b, tbl[0].m, 48, 1, 1);
        drain();
        for (int i = 0; i < 4; i++) put(tbl[3].b[i], 2'b11);
        reset_pulse();
        run_frame(tbl[3].b, 2'b11, 0, 0, 0);
        repeat (5) @(negedge clk);
        reset_pulse();
        repeat (25) @(negedge clk);
        run_frame(tbl[0].b, 2'b11, 48, 0, 1);
        drain();
        chk("queue_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
